// File: rtl/pscb_cfg_loader.sv
// Configuration loader for the PSCB pass-generation tree.
// Streams WORD_W-bit words into a staging image and commits the whole image
// atomically to the active outputs once the network is no longer held busy.
module pscb_cfg_loader #(
  parameter int unsigned INPUTS = 128,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned WORD_W = 32,
  localparam int unsigned NODES  = INPUTS / 2,
  localparam int unsigned STAGES = $clog2(INPUTS),
  localparam int unsigned CFG_W  = NODES * STAGES,
  localparam int unsigned WORDS  = (CFG_W + WORD_W - 1) / WORD_W,
  localparam int unsigned CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_pass_start,
  input  logic              i_valid,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_ready,
  input  logic              i_abort,
  input  logic              i_hold,
  output logic [CFG_W-1:0]  o_scb,
  output logic [DATA_W-1:0] o_pass_start,
  output logic              o_cfg_valid,
  output logic              o_busy,
  output logic              o_err
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPend
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CFG_W-1:0]   stg_q, stg_d;
  logic [DATA_W-1:0]  idx_q, idx_d;

  logic start_ok;
  logic start_acc;
  logic word_acc;

  // Index must address a real network input; wider encodings are rejected.
  assign start_ok  = 32'(i_pass_start) < INPUTS;
  assign start_acc = (state_q == StIdle) && i_start && start_ok;
  // Abort wins over a word offered in the same cycle.
  assign word_acc  = (state_q == StLoad) && i_valid && !i_abort;

  assign o_ready = (state_q == StLoad);
  assign o_busy  = (state_q != StIdle);

  // Staging next-state: capture index on start, write the addressed word slice.
  // Only bits below CFG_W exist, so the tail of an oversized final word is dropped.
  always_comb begin
    stg_d = stg_q;
    idx_d = idx_q;
    if (start_acc) begin
      idx_d = i_pass_start;
    end
    if (word_acc) begin
      for (int b = 0; b < int'(CFG_W); b++) begin
        if (cnt_q == CNT_W'(b / int'(WORD_W))) begin
          stg_d[b] = i_word[b % int'(WORD_W)];
        end
      end
    end
  end

  // Staging storage is deliberately not reset; it is only observed after a full load.
  always_ff @(posedge i_clk) begin
    stg_q <= stg_d;
    idx_q <= idx_d;
  end

  // Control FSM with registered active outputs and status pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      o_scb        <= '0;
      o_pass_start <= '0;
      o_cfg_valid  <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_cfg_valid <= 1'b0;
      o_err       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            if (start_ok) begin
              cnt_q   <= '0;
              state_q <= StLoad;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (i_abort) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (i_valid) begin
            // Counter saturates at the last word instead of wrapping.
            if (cnt_q == LastCnt) begin
              state_q <= StPend;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        StPend: begin
          if (i_abort) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else if (!i_hold) begin
            o_scb        <= stg_q;
            o_pass_start <= idx_q;
            o_cfg_valid  <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StIdle;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pscb_cfg_loader.sv
// Self-checking bench for pscb_cfg_loader: start-decision vector table, directed
// load/hold/abort sequences and randomized loads against an image-level model.
module tb_pscb_cfg_loader;

  localparam int unsigned INPUTS = 128;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CFG_W  = (INPUTS / 2) * $clog2(INPUTS);
  localparam int unsigned WORDS  = (CFG_W + WORD_W - 1) / WORD_W;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] pass_start;
  logic              valid;
  logic [WORD_W-1:0] word;
  logic              ready;
  logic              abort;
  logic              hold;
  logic [CFG_W-1:0]  scb;
  logic [DATA_W-1:0] ps_out;
  logic              cfg_valid;
  logic              busy;
  logic              err;

  pscb_cfg_loader #(
    .INPUTS(INPUTS),
    .DATA_W(DATA_W),
    .WORD_W(WORD_W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_pass_start(pass_start),
    .i_valid     (valid),
    .i_word      (word),
    .o_ready     (ready),
    .i_abort     (abort),
    .i_hold      (hold),
    .o_scb       (scb),
    .o_pass_start(ps_out),
    .o_cfg_valid (cfg_valid),
    .o_busy      (busy),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the image the tree should currently see.
  logic [CFG_W-1:0]  mdl_scb;
  logic [DATA_W-1:0] mdl_ps;
  logic [WORD_W-1:0] wq [WORDS];

  typedef struct {
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] ps;
    logic              exp_err;
    logic              exp_busy;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [CFG_W-1:0] act,
                     input logic [CFG_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected image: words laid end to end, anything past CFG_W discarded.
  function automatic logic [CFG_W-1:0] image();
    logic [WORDS*WORD_W-1:0] full;
    for (int k = 0; k < int'(WORDS); k++) full[k*WORD_W +: WORD_W] = wq[k];
    return full[CFG_W-1:0];
  endfunction

  function automatic void fill_random();
    for (int k = 0; k < int'(WORDS); k++) wq[k] = $urandom;
  endfunction

  // One complete load attempt. abort_at: word index to abort on (WORDS = abort
  // in PEND), negative for none.
  task automatic run_load(input logic [DATA_W-1:0] ps, input int hold_cyc,
                          input bit gaps, input int abort_at);
    hold       = (hold_cyc > 0);
    start      = 1'b1;
    pass_start = ps;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    for (int k = 0; k < int'(WORDS); k++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          valid = 1'b0;
          tick();
        end
      end
      if (k == abort_at) begin
        valid = 1'b1;
        word  = $urandom;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        chk("abort_scb", scb, mdl_scb);
        chk("abort_ps", ps_out, mdl_ps);
        chk("abort_nocv", cfg_valid, 0);
        return;
      end
      valid = 1'b1;
      word  = wq[k];
      tick();
      valid = 1'b0;
    end
    chk("pend_ready", ready, 0);
    chk("pend_busy", busy, 1);
    chk("pend_scb_old", scb, mdl_scb);
    if (abort_at == int'(WORDS)) begin
      hold  = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("pabort_busy", busy, 0);
      chk("pabort_scb", scb, mdl_scb);
      chk("pabort_ps", ps_out, mdl_ps);
      chk("pabort_nocv", cfg_valid, 0);
      return;
    end
    for (int h = 0; h < hold_cyc; h++) begin
      tick();
      chk("hold_scb", scb, mdl_scb);
      chk("hold_busy", busy, 1);
      chk("hold_ready", ready, 0);
      chk("hold_nocv", cfg_valid, 0);
    end
    hold = 1'b0;
    tick();
    mdl_scb = image();
    mdl_ps  = ps;
    chk("commit_cv", cfg_valid, 1);
    chk("commit_scb", scb, mdl_scb);
    chk("commit_ps", ps_out, mdl_ps);
    tick();
    chk("cv_pulse", cfg_valid, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    vecs[0] = '{start: 1'b1, abort: 1'b0, ps: 8'd5,   exp_err: 1'b0, exp_busy: 1'b1};
    vecs[1] = '{start: 1'b1, abort: 1'b0, ps: 8'd127, exp_err: 1'b0, exp_busy: 1'b1};
    vecs[2] = '{start: 1'b1, abort: 1'b0, ps: 8'd128, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{start: 1'b1, abort: 1'b0, ps: 8'd255, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{start: 1'b1, abort: 1'b0, ps: 8'd0,   exp_err: 1'b0, exp_busy: 1'b1};
    vecs[5] = '{start: 1'b0, abort: 1'b0, ps: 8'd200, exp_err: 1'b0, exp_busy: 1'b0};
    vecs[6] = '{start: 1'b1, abort: 1'b1, ps: 8'd10,  exp_err: 1'b0, exp_busy: 1'b1};

    rst_n = 1'b0; start = 1'b0; pass_start = '0; valid = 1'b0; word = '0;
    abort = 1'b0; hold = 1'b0;
    mdl_scb = '0;
    mdl_ps  = '0;

    #12;
    chk("rst_scb", scb, '0);
    chk("rst_ps", ps_out, '0);
    chk("rst_cv", cfg_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Start decisions in IDLE.
    foreach (vecs[i]) begin
      start      = vecs[i].start;
      abort      = vecs[i].abort;
      pass_start = vecs[i].ps;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("vec_err", err, vecs[i].exp_err);
      chk("vec_busy", busy, vecs[i].exp_busy);
      chk("vec_ready", ready, vecs[i].exp_busy);
      tick();
      chk("vec_err_pulse", err, 0);
      chk("vec_busy_hold", busy, vecs[i].exp_busy);
      if (busy) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("vec_abort_idle", busy, 0);
      end
    end

    // Full back-to-back load with counting pattern.
    for (int k = 0; k < int'(WORDS); k++) wq[k] = WORD_W'(k);
    run_load(8'd5, 0, 1'b0, -1);
    chk("full_lo", scb[31:0], 32'h0);
    chk("full_hi", scb[447:416], 32'hD);
    chk("full_ps", ps_out, 8'd5);

    // Commit deferred by hold.
    fill_random();
    run_load(8'd77, 10, 1'b0, -1);

    // Throttled valid with an all-ones final word.
    fill_random();
    wq[WORDS-1] = 32'hFFFF_FFFF;
    run_load(8'd100, 0, 1'b1, -1);
    chk("thr_top", scb[447:416], 32'hFFFF_FFFF);

    // Abort after seven words, then a clean reload.
    fill_random();
    run_load(8'd33, 0, 1'b0, 7);
    fill_random();
    run_load(8'd34, 2, 1'b0, -1);

    // Abort in PEND beats a same-cycle commit.
    fill_random();
    run_load(8'd44, 0, 1'b0, int'(WORDS));

    // Start while loading is ignored; captured index stays.
    fill_random();
    start = 1'b1; pass_start = 8'd9;
    tick();
    start = 1'b0;
    for (int k = 0; k < int'(WORDS); k++) begin
      valid = 1'b1;
      word  = wq[k];
      if (k == 3) begin
        start      = 1'b1;
        pass_start = 8'd50;
      end
      tick();
      start = 1'b0;
      valid = 1'b0;
      if (k == 3) chk("load_start_noerr", err, 0);
    end
    tick();
    mdl_scb = image();
    mdl_ps  = 8'd9;
    chk("ign_cv", cfg_valid, 1);
    chk("ign_ps", ps_out, mdl_ps);
    chk("ign_scb", scb, mdl_scb);
    tick();

    // Randomized loads.
    for (int r = 0; r < 10; r++) begin
      fill_random();
      run_load(DATA_W'($urandom_range(0, INPUTS - 1)), $urandom_range(0, 3),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? $urandom_range(0, WORDS) : -1);
    end

    // Asynchronous reset in the middle of a load.
    fill_random();
    start = 1'b1; pass_start = 8'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      word  = wq[k];
      tick();
    end
    valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_scb", scb, '0);
    chk("mrst_ps", ps_out, '0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
